// File: rtl/mac_seq_pkg.sv
// Shared definitions for the MAC cluster sequencer: combine-mode codes,
// FSM state encodings and the mode legality check.
package mac_seq_pkg;

    localparam logic [1:0] MAC_SINGLE = 2'b00;
    localparam logic [1:0] MAC_DUAL   = 2'b01;
    localparam logic [1:0] MAC_QUAD   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    function automatic logic cfg_is_legal(input logic [1:0] cfg);
        return (cfg == MAC_SINGLE) || (cfg == MAC_DUAL) || (cfg == MAC_QUAD);
    endfunction

endpackage

// File: rtl/mac_cluster_sequencer_if.sv
// Command, operand, lane-control and result signals between the layer
// scheduler (master) and the MAC cluster sequencer (slave).
interface mac_cluster_sequencer_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_cfg;
    logic [CNT_WIDTH-1:0] cmd_len;
    logic                 cmd_err;
    logic                 op_valid;
    logic                 op_ready;
    logic                 mac_en;
    logic                 mac_clr;
    logic [1:0]           mac_cfg;
    logic                 comb_en;
    logic                 res_valid;
    logic                 res_ready;
    logic                 busy;

    modport master (
        output cmd_valid, cmd_cfg, cmd_len, op_valid, res_ready,
        input  cmd_ready, cmd_err, op_ready, mac_en, mac_clr, mac_cfg,
               comb_en, res_valid, busy
    );

    modport slave (
        input  cmd_valid, cmd_cfg, cmd_len, op_valid, res_ready,
        output cmd_ready, cmd_err, op_ready, mac_en, mac_clr, mac_cfg,
               comb_en, res_valid, busy
    );

endinterface

// File: rtl/mac_seq_downcnt.sv
// Loadable down-counter with zero/one flags. Clear beats load, load beats
// decrement, and a decrement at zero holds so the count can never wrap.
module mac_seq_downcnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             one_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // NOTE: cnt_d gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign one_o  = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/mac_cluster_sequencer.sv
// Job-level controller for a 4-lane MAC cluster: takes a command, gates lane
// enables per operand beat, waits out the MAC pipeline and holds the result.
module mac_cluster_sequencer
    import mac_seq_pkg::*;
#(
    parameter int CNT_WIDTH   = 8,
    parameter int MAC_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   abort,
    mac_cluster_sequencer_if.slave bus
);

    localparam int DRAIN_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY + 1) : 1;

    seq_state_e state_q;
    logic [1:0] mac_cfg_q;
    logic       cmd_err_q;
    logic       first_q;

    logic cmd_fire;
    logic cmd_legal;
    logic beat_fire;
    logic beat_last;
    logic drain_load;
    logic drain_dec;
    logic drain_last;
    logic beat_zero;
    logic beat_one;
    logic drain_zero;
    logic drain_one;

    // Abort masks every handshake in its cycle so nothing half-completes.
    assign bus.cmd_ready = (state_q == ST_IDLE) && !abort;
    assign bus.op_ready  = (state_q == ST_RUN) && !abort;
    assign bus.res_valid = (state_q == ST_DONE) && !abort;
    assign bus.mac_en    = bus.op_valid && bus.op_ready;
    assign bus.mac_clr   = bus.mac_en && first_q;
    assign bus.mac_cfg   = mac_cfg_q;
    assign bus.cmd_err   = cmd_err_q;
    assign bus.comb_en   = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);

    assign cmd_fire   = bus.cmd_valid && bus.cmd_ready;
    assign cmd_legal  = cfg_is_legal(bus.cmd_cfg) && (bus.cmd_len != '0);
    assign beat_fire  = bus.mac_en;
    assign beat_last  = beat_fire && (beat_one || beat_zero);
    assign drain_load = beat_last && (MAC_LATENCY != 0);
    assign drain_dec  = (state_q == ST_DRAIN) && !abort;
    assign drain_last = drain_one || drain_zero;

    mac_seq_downcnt #(
        .WIDTH(CNT_WIDTH)
    ) u_beat_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (abort),
        .load_i    (cmd_fire && cmd_legal),
        .load_val_i(bus.cmd_len),
        .dec_i     (beat_fire),
        .zero_o    (beat_zero),
        .one_o     (beat_one)
    );

    mac_seq_downcnt #(
        .WIDTH(DRAIN_W)
    ) u_drain_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (abort),
        .load_i    (drain_load),
        .load_val_i(DRAIN_W'(MAC_LATENCY)),
        .dec_i     (drain_dec),
        .zero_o    (drain_zero),
        .one_o     (drain_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mac_cfg_q <= MAC_SINGLE;
            cmd_err_q <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            cmd_err_q <= 1'b0;
            if (abort) begin
                state_q <= ST_IDLE;
                first_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (cmd_fire) begin
                            if (!cmd_legal) begin
                                cmd_err_q <= 1'b1;
                            end else begin
                                mac_cfg_q <= bus.cmd_cfg;
                                first_q   <= 1'b1;
                                state_q   <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (beat_fire) begin
                            first_q <= 1'b0;
                        end
                        if (beat_last) begin
                            state_q <= (MAC_LATENCY > 0) ? ST_DRAIN : ST_DONE;
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_last) begin
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (bus.res_ready) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
